// File: rtl/data_mem_initiator.sv
// Data-memory bus initiator: turns load/store/stack/IO requests into timed memory_map
// accesses, forms effective addresses, updates pointers and captures read data.
module data_mem_initiator #(
    parameter int unsigned RD_LAT_REGIO = 2,
    parameter int unsigned RD_LAT_SRAM  = 4,
    parameter int unsigned WR_HOLD      = 3,
    parameter logic [15:0] SRAM_TOP     = 16'h085F
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        is_write_i,
    input  logic [2:0]  mode_i,
    input  logic [15:0] ptr_in_i,
    input  logic [5:0]  disp_i,
    input  logic [5:0]  io_addr_i,
    input  logic [7:0]  wdata_i,
    output logic [15:0] mm_addr_o,
    output logic        mm_we_o,
    output logic [7:0]  mm_data_o,
    output logic        mm_io_only_o,
    input  logic [7:0]  mm_q_i,
    output logic [7:0]  rdata_o,
    output logic [15:0] ptr_out_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic [3:0] LAT_REGIO = 4'(RD_LAT_REGIO);
    localparam logic [3:0] LAT_SRAM  = 4'(RD_LAT_SRAM);
    localparam logic [3:0] LAT_WR    = 4'(WR_HOLD);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d, lat_q, lat_d;
    logic        wr_q, wr_d, we_q, we_d, io_q, io_d, err_q, err_d;
    logic [15:0] addr_q, addr_d, ptr_q, ptr_d;
    logic [7:0]  data_q, data_d, rdata_q, rdata_d;

    logic [15:0] ea, ptr_nx;
    logic        wr_eff, io_m, rsv, ea_err;
    logic [3:0]  lat_sel;

    // Address/pointer decode of the request as presented; only used at accept.
    always_comb begin
        ea     = ptr_in_i;
        ptr_nx = ptr_in_i;
        wr_eff = is_write_i;
        io_m   = 1'b0;
        rsv    = 1'b0;
        case (mode_i)
            3'd0: ea = ptr_in_i;
            3'd1: ptr_nx = ptr_in_i + 16'd1;
            3'd2: begin
                ea     = ptr_in_i - 16'd1;
                ptr_nx = ptr_in_i - 16'd1;
            end
            3'd3: ea = ptr_in_i + {10'b0, disp_i};
            3'd4: begin
                ea   = {10'b0, io_addr_i};
                io_m = 1'b1;
            end
            3'd5: begin
                wr_eff = 1'b1;
                ptr_nx = ptr_in_i - 16'd1;
            end
            3'd6: begin
                wr_eff = 1'b0;
                ea     = ptr_in_i + 16'd1;
                ptr_nx = ptr_in_i + 16'd1;
            end
            default: rsv = 1'b1;
        endcase
        if (wr_eff)
            lat_sel = LAT_WR;
        else if (io_m || ea <= 16'h005F)
            lat_sel = LAT_REGIO;
        else
            lat_sel = LAT_SRAM;
        ea_err = !io_m && (ea > SRAM_TOP);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        wr_d    = wr_q;
        we_d    = 1'b0;
        io_d    = io_q;
        err_d   = err_q;
        addr_d  = addr_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_i) begin
                ptr_d = ptr_nx;
                if (rsv) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                    lat_d   = lat_sel;
                    wr_d    = wr_eff;
                    we_d    = wr_eff;
                    io_d    = io_m;
                    err_d   = ea_err;
                    addr_d  = ea;
                    data_d  = wr_eff ? wdata_i : 8'h00;
                end
            end
            ACCESS: begin
                if (cnt_q == lat_q - 4'd1) begin
                    state_d = DONE;
                    if (!wr_q)
                        rdata_d = mm_q_i;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                addr_d  = 16'h0000;
                data_d  = 8'h00;
                io_d    = 1'b0;
                err_d   = 1'b0;
                ptr_d   = 16'h0000;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            lat_q   <= 4'd0;
            wr_q    <= 1'b0;
            we_q    <= 1'b0;
            io_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 16'h0000;
            data_q  <= 8'h00;
            ptr_q   <= 16'h0000;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            wr_q    <= wr_d;
            we_q    <= we_d;
            io_q    <= io_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
            rdata_q <= rdata_d;
        end
    end

    assign ready_o      = (state_q == IDLE);
    assign done_o       = (state_q == DONE);
    assign err_o        = done_o & err_q;
    assign mm_addr_o    = addr_q;
    assign mm_we_o      = we_q;
    assign mm_data_o    = data_q;
    assign mm_io_only_o = io_q;
    assign rdata_o      = rdata_q;
    assign ptr_out_o    = ptr_q;

endmodule
